axi_lite_reg_bridge: RTL

- Consumes the axi_lite_req_t / axi_lite_rsp_t pair produced by the AXI4-Lite slave connector and converts it into a single-beat register-access port for the IOMMU register file.
- Serialises reads and writes: one outstanding access at a time, with round-robin arbitration between reads and writes.
- Performs address-window decode. Out-of-window accesses are answered with DECERR and never reach the register file.

---
 rtl/axi_lite_reg_pkg.sv | 39 +++
 rtl/axi_lite_reg_timeout.sv | 24 ++
 rtl/axi_lite_reg_bridge.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/axi_lite_reg_pkg.sv
// Shared types for the AXI-Lite register bridge: state/priority enums, response
// codes, and the connector's request/response structs (fixed at 64-bit address/data).
package axi_lite_reg_pkg;

  localparam int AXI_ADDR_W = 64;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  typedef struct packed {
    logic                  aw_valid;
    logic [AXI_ADDR_W-1:0] aw_addr;
    logic                  w_valid;
    logic [AXI_DATA_W-1:0] w_data;
    logic [AXI_STRB_W-1:0] w_strb;
    logic                  b_ready;
    logic                  ar_valid;
    logic [AXI_ADDR_W-1:0] ar_addr;
    logic                  r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic                  aw_ready;
    logic                  w_ready;
    logic                  b_valid;
    logic [1:0]            b_resp;
    logic                  ar_ready;
    logic                  r_valid;
    logic [AXI_DATA_W-1:0] r_data;
    logic [1:0]            r_resp;
  } axi_lite_rsp_t;

  typedef enum logic [2:0] {IDLE, REG_WR, REG_RD, SEND_B, SEND_R} state_e;
  typedef enum logic {PRIO_READ, PRIO_WRITE} prio_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_reg_timeout.sv
// Register-access watchdog: counts cycles spent waiting on the register file and
// flags expiry on the TIMEOUT_CYCLES-th waiting cycle.
module axi_lite_reg_timeout #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_active,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  // Cleared whenever the bridge is not waiting, so every access starts from zero.
  always_ff @(posedge clk_i) begin
    if (rst_i || !i_active) r_cnt <= '0;
    else if (!o_expired)    r_cnt <= r_cnt + CW'(1);
  end

  assign o_expired = i_active && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axi_lite_reg_bridge.sv
// AXI-Lite to single-beat register port bridge with window decode and read/write
// round-robin. Optional watchdog enabled by defining AXI_LITE_REG_TIMEOUT_EN.
module axi_lite_reg_bridge
  import axi_lite_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 64,
  parameter int                    ADDR_WIDTH     = 64,
  parameter int                    STRB_WIDTH     = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    WIN_SIZE       = 4096,
  parameter int                    TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  axi_lite_req_t         axi_lite_req_i,
  output axi_lite_rsp_t         axi_lite_rsp_o,
  output logic                  reg_valid_o,
  output logic                  reg_write_o,
  output logic [ADDR_WIDTH-1:0] reg_addr_o,
  output logic [DATA_WIDTH-1:0] reg_wdata_o,
  output logic [STRB_WIDTH-1:0] reg_wstrb_o,
  input  logic                  reg_ready_i,
  input  logic [DATA_WIDTH-1:0] reg_rdata_i,
  input  logic                  reg_error_i
);

  if ((DATA_WIDTH != 32 && DATA_WIDTH != 64) || TIMEOUT_CYCLES < 1 || WIN_SIZE < STRB_WIDTH) begin : g_bad_cfg
    $error("axi_lite_reg_bridge: unsupported parameter combination");
  end

  localparam logic [ADDR_WIDTH-1:0] WIN_MASK  = ADDR_WIDTH'(WIN_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

  state_e                r_state;
  prio_e                 r_prio;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic                  r_write, r_reg_valid, r_bvalid, r_rvalid;
  logic [1:0]            r_resp;

  logic                  w_wr_cand, w_rd_cand, w_pick_wr, w_pick_rd;
  logic                  w_accept, w_hit, w_in_reg, w_expired, w_done;
  logic [ADDR_WIDTH-1:0] w_addr, w_off;

  assign w_wr_cand = axi_lite_req_i.aw_valid & axi_lite_req_i.w_valid;
  assign w_rd_cand = axi_lite_req_i.ar_valid;
  assign w_pick_wr = w_wr_cand & (~w_rd_cand | (r_prio == PRIO_WRITE));
  assign w_pick_rd = w_rd_cand & ~w_pick_wr;
  // Readies are gated by reset so nothing appears accepted while it is being discarded.
  assign w_accept  = (r_state == IDLE) & ~rst_i & (w_pick_wr | w_pick_rd);

  assign w_addr = w_pick_wr ? axi_lite_req_i.aw_addr[ADDR_WIDTH-1:0]
                            : axi_lite_req_i.ar_addr[ADDR_WIDTH-1:0];
  // BASE_ADDR is window-aligned, so a masked compare is the full range check.
  assign w_hit  = (w_addr & ~WIN_MASK) == BASE_ADDR;
  assign w_off  = (w_addr - BASE_ADDR) & WORD_MASK;

  assign w_in_reg = (r_state == REG_WR) || (r_state == REG_RD);

`ifdef AXI_LITE_REG_TIMEOUT_EN
  axi_lite_reg_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_active  (w_in_reg),
    .o_expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  // A ready coinciding with expiry takes priority: its data and error are used.
  assign w_done = reg_ready_i | w_expired;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_prio      <= PRIO_READ;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_wstrb     <= '0;
      r_write     <= 1'b0;
      r_reg_valid <= 1'b0;
      r_bvalid    <= 1'b0;
      r_rvalid    <= 1'b0;
      r_resp      <= RESP_OKAY;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_write <= w_pick_wr;
          r_addr  <= w_off;
          r_wdata <= w_pick_wr ? axi_lite_req_i.w_data[DATA_WIDTH-1:0] : '0;
          r_wstrb <= w_pick_wr ? axi_lite_req_i.w_strb[STRB_WIDTH-1:0] : '0;
          r_rdata <= '0;
          r_prio  <= w_pick_wr ? PRIO_READ : PRIO_WRITE;
          if (w_hit) begin
            r_reg_valid <= 1'b1;
            r_state     <= w_pick_wr ? REG_WR : REG_RD;
          end else begin
            r_resp   <= RESP_DECERR;
            r_bvalid <= w_pick_wr;
            r_rvalid <= ~w_pick_wr;
            r_state  <= w_pick_wr ? SEND_B : SEND_R;
          end
        end
        REG_WR, REG_RD: if (w_done) begin
          r_reg_valid <= 1'b0;
          r_resp      <= (reg_ready_i && !reg_error_i) ? RESP_OKAY : RESP_SLVERR;
          if (r_state == REG_RD && reg_ready_i) r_rdata <= reg_rdata_i;
          r_bvalid    <= (r_state == REG_WR);
          r_rvalid    <= (r_state == REG_RD);
          r_state     <= (r_state == REG_WR) ? SEND_B : SEND_R;
        end
        SEND_B: if (axi_lite_req_i.b_ready) begin
          r_bvalid <= 1'b0;
          r_state  <= IDLE;
        end
        SEND_R: if (axi_lite_req_i.r_ready) begin
          r_rvalid <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    axi_lite_rsp_o          = '0;
    axi_lite_rsp_o.aw_ready = w_accept & w_pick_wr;
    axi_lite_rsp_o.w_ready  = w_accept & w_pick_wr;
    axi_lite_rsp_o.ar_ready = w_accept & w_pick_rd;
    axi_lite_rsp_o.b_valid  = r_bvalid;
    axi_lite_rsp_o.b_resp   = r_resp;
    axi_lite_rsp_o.r_valid  = r_rvalid;
    axi_lite_rsp_o.r_resp   = r_resp;
    axi_lite_rsp_o.r_data   = AXI_DATA_W'(r_rdata);
  end

  assign reg_valid_o = r_reg_valid;
  assign reg_write_o = r_write;
  assign reg_addr_o  = r_addr;
  assign reg_wdata_o = r_wdata;
  assign reg_wstrb_o = r_wstrb;

endmodule
